// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray counter receive path.
// Helpers operate on 32-bit values; callers zero-extend narrower codes.
package gray_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    TRACK = 1'b1
  } state_t;

  typedef struct packed {
    logic up;
    logic down;
    logic err;
  } ev_t;

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] popcount(input logic [31:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_sync_chain.sv
// Reset-to-zero multi-flop synchronizer for a Gray-coded bus.
// Only one bit of the bus changes per source step, so per-bit sync is safe.
module gray_sync_chain #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/gray_sync_decoder.sv
// Synchronizes a Gray counter, decodes it and classifies each step.
// Optional direction check enabled by GRAY_SYNC_DIR_CHECK_EN.
module gray_sync_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = 8
`ifdef GRAY_SYNC_DIR_CHECK_EN
  ,
  parameter int EXPECT_DIR  = 0
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 clear,
  output logic [WIDTH-1:0]     gray_out,
  output logic [WIDTH-1:0]     binary_out,
  output logic                 valid_out,
  output logic                 step_up,
  output logic                 step_down,
  output logic                 err_pulse,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count
`ifdef GRAY_SYNC_DIR_CHECK_EN
  ,
  output logic                 err_dir
`endif
);

  localparam int FILL_N = SYNC_STAGES + 1;
  localparam int CNT_W  = $clog2(FILL_N);

  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_N - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic             track;

  logic [WIDTH-1:0] sync_w;
  logic [WIDTH-1:0] cur_q, prev_q;
  logic [WIDTH-1:0] bin_new, bin_prev, diff;
  logic [WIDTH-1:0] bin_q;

  ev_t  ev_d, ev_q;
  logic err_d;

  logic                 sticky_q;
  logic [ERR_CNT_W-1:0] cnt_q;

  gray_sync_chain #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (gray_in),
    .q_o  (sync_w)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    unique case (state_q)
      FILL: begin
        fill_d = fill_q + CNT_W'(1);
        if (fill_q == FILL_LAST) begin
          state_d = TRACK;
        end
      end
      TRACK: state_d = TRACK;
    endcase
  end

  always_comb begin
    track = 1'b0;
    unique case (state_q)
      FILL:  track = 1'b0;
      TRACK: track = 1'b1;
    endcase
  end

  assign valid_out = track;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_q  <= '0;
      prev_q <= '0;
    end else begin
      cur_q  <= sync_w;
      prev_q <= cur_q;
    end
  end

  assign bin_new  = WIDTH'(gray2bin(32'(cur_q)));
  assign bin_prev = WIDTH'(gray2bin(32'(prev_q)));
  assign diff     = cur_q ^ prev_q;

  // Single-bit Gray change may still be an illegal jump in binary.
  always_comb begin
    logic one_bit;
    one_bit   = popcount(32'(diff)) == 32'd1;
    ev_d.up   = one_bit && (bin_new == bin_prev + WIDTH'(1));
    ev_d.down = one_bit && (bin_new == bin_prev - WIDTH'(1));
    ev_d.err  = (diff != '0) && !ev_d.up && !ev_d.down;
  end

`ifdef GRAY_SYNC_DIR_CHECK_EN
  logic dir_d, dir_q;

  assign dir_d = (EXPECT_DIR == 0) ? ev_d.down : ev_d.up;
  assign err_d = track && (ev_d.err || dir_d);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dir_q <= 1'b0;
    end else begin
      dir_q <= track && dir_d;
    end
  end

  assign err_dir = dir_q;
`else
  assign err_d = track && ev_d.err;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ev_q  <= '0;
      bin_q <= '0;
    end else begin
      ev_q.up   <= track && ev_d.up;
      ev_q.down <= track && ev_d.down;
      ev_q.err  <= err_d;
      bin_q     <= bin_new;
    end
  end

  // A new error wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else if (clear) begin
      sticky_q <= err_d;
      cnt_q    <= err_d ? ERR_CNT_W'(1) : '0;
    end else if (err_d) begin
      sticky_q <= 1'b1;
      if (cnt_q != '1) begin
        cnt_q <= cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  assign gray_out   = cur_q;
  assign binary_out = bin_q;
  assign step_up    = ev_q.up;
  assign step_down  = ev_q.down;
  assign err_pulse  = ev_q.err;
  assign err_sticky = sticky_q;
  assign err_count  = cnt_q;

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Directed bench for gray_sync_decoder (WIDTH=4, SYNC_STAGES=2, ERR_CNT_W=2).
// Covers err_dir too when GRAY_SYNC_DIR_CHECK_EN is defined.
module tb_gray_sync_decoder;

  logic       clk;
  logic       rst_n;
  logic [3:0] gray_in;
  logic       clear;
  logic [3:0] gray_out;
  logic [3:0] binary_out;
  logic       valid_out;
  logic       step_up;
  logic       step_down;
  logic       err_pulse;
  logic       err_sticky;
  logic [1:0] err_count;
`ifdef GRAY_SYNC_DIR_CHECK_EN
  logic       err_dir;
`endif

  int checks = 0;
  int errors = 0;

  logic [3:0] gtab [16] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0111, 4'b0101, 4'b0100,
    4'b1100, 4'b1101, 4'b1111, 4'b1110,
    4'b1010, 4'b1011, 4'b1001, 4'b1000
  };

  gray_sync_decoder #(
    .WIDTH      (4),
    .SYNC_STAGES(2),
    .ERR_CNT_W  (2)
`ifdef GRAY_SYNC_DIR_CHECK_EN
    ,
    .EXPECT_DIR (0)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gray_in   (gray_in),
    .clear     (clear),
    .gray_out  (gray_out),
    .binary_out(binary_out),
    .valid_out (valid_out),
    .step_up   (step_up),
    .step_down (step_down),
    .err_pulse (err_pulse),
    .err_sticky(err_sticky),
    .err_count (err_count)
`ifdef GRAY_SYNC_DIR_CHECK_EN
    ,
    .err_dir   (err_dir)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [3:0] g);
    gray_in = g;
    repeat (4) tick();
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    gray_in = 4'b0000;
    clear   = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    gray_in = 4'b0000;
    clear   = 1'b0;
    repeat (3) tick();
    checks++;
    if ({valid_out, gray_out, binary_out} !== 9'd0) begin
      errors++;
      $display("FAIL rst_data got v=%b g=%b b=%0d exp 0", valid_out, gray_out, binary_out);
    end
    checks++;
    if ({step_up, step_down, err_pulse, err_sticky, err_count} !== 6'd0) begin
      errors++;
      $display("FAIL rst_flags got %b%b%b%b cnt=%0d exp 0", step_up, step_down, err_pulse, err_sticky, err_count);
    end
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL fill_valid got %b exp 0", valid_out);
    end
    tick();
    checks++;
    if (valid_out !== 1'b1 || binary_out !== 4'd0) begin
      errors++;
      $display("FAIL track_valid got v=%b b=%0d exp v=1 b=0", valid_out, binary_out);
    end
    repeat (3) tick();
    checks++;
    if ({step_up, step_down, err_pulse} !== 3'b000) begin
      errors++;
      $display("FAIL idle_pulses got %b%b%b exp 000", step_up, step_down, err_pulse);
    end
  endtask

  task automatic test_step_up();
    for (int i = 1; i <= 16; i++) begin
      gray_in = gtab[i % 16];
      tick();
      checks++;
      if ({step_up, step_down, err_pulse} !== 3'b000) begin
        errors++;
        $display("FAIL up_gap%0d got %b%b%b exp 000", i, step_up, step_down, err_pulse);
      end
      tick();
      if (i >= 2) begin
        checks++;
        if (step_up !== 1'b1 || err_pulse !== 1'b0 || binary_out !== 4'(i - 1)) begin
          errors++;
          $display("FAIL up%0d got up=%b err=%b b=%0d exp up=1 err=0 b=%0d", i, step_up, err_pulse, binary_out, i - 1);
        end
      end
    end
    tick();
    tick();
    checks++;
    if (step_up !== 1'b1 || step_down !== 1'b0 || binary_out !== 4'd0) begin
      errors++;
      $display("FAIL up_wrap got up=%b dn=%b b=%0d exp up=1 dn=0 b=0", step_up, step_down, binary_out);
    end
    checks++;
    if (err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL up_sticky got %b exp 0", err_sticky);
    end
  endtask

  task automatic test_step_down();
    repeat (2) tick();
    gray_in = 4'b1000;
    repeat (3) tick();
    checks++;
    if (gray_out !== 4'b1000) begin
      errors++;
      $display("FAIL dn_latency got %b exp 1000", gray_out);
    end
    tick();
    checks++;
    if (step_down !== 1'b1 || step_up !== 1'b0 || binary_out !== 4'd15) begin
      errors++;
      $display("FAIL dn_wrap got dn=%b up=%b b=%0d exp dn=1 up=0 b=15", step_down, step_up, binary_out);
    end
    tick();
    checks++;
    if (step_down !== 1'b0) begin
      errors++;
      $display("FAIL dn_width got %b exp 0", step_down);
    end
    apply(4'b1001);
    checks++;
    if (step_down !== 1'b1 || err_pulse !== 1'b0 || binary_out !== 4'd14) begin
      errors++;
      $display("FAIL dn_14 got dn=%b err=%b b=%0d exp dn=1 err=0 b=14", step_down, err_pulse, binary_out);
    end
  endtask

  task automatic test_errors();
    do_reset();
    apply(4'b0011);
    checks++;
    if (err_pulse !== 1'b1 || binary_out !== 4'd2 || err_count !== 2'd1) begin
      errors++;
      $display("FAIL jump_0_3 got e=%b b=%0d c=%0d exp e=1 b=2 c=1", err_pulse, binary_out, err_count);
    end
    apply(4'b0001);
    checks++;
    if (step_down !== 1'b1 || err_pulse !== 1'b0 || binary_out !== 4'd1) begin
      errors++;
      $display("FAIL legal_2_1 got dn=%b e=%b b=%0d exp dn=1 e=0 b=1", step_down, err_pulse, binary_out);
    end
    apply(4'b0101);
    checks++;
    if (err_pulse !== 1'b1 || step_up !== 1'b0 || binary_out !== 4'd6) begin
      errors++;
      $display("FAIL onebit_jump got e=%b up=%b b=%0d exp e=1 up=0 b=6", err_pulse, step_up, binary_out);
    end
    checks++;
    if (err_sticky !== 1'b1 || err_count !== 2'd2) begin
      errors++;
      $display("FAIL err_cnt2 got s=%b c=%0d exp s=1 c=2", err_sticky, err_count);
    end
    apply(4'b0000);
    checks++;
    if (err_pulse !== 1'b1 || err_count !== 2'd3) begin
      errors++;
      $display("FAIL err_cnt3 got e=%b c=%0d exp e=1 c=3", err_pulse, err_count);
    end
    apply(4'b0011);
    checks++;
    if (err_pulse !== 1'b1 || err_count !== 2'd3 || binary_out !== 4'd2) begin
      errors++;
      $display("FAIL err_sat got e=%b c=%0d b=%0d exp e=1 c=3 b=2", err_pulse, err_count, binary_out);
    end
  endtask

  task automatic test_clear();
    gray_in = 4'b0101;
    repeat (3) tick();
    clear = 1'b1;
    tick();
    checks++;
    if (err_pulse !== 1'b1 || err_sticky !== 1'b1 || err_count !== 2'd1) begin
      errors++;
      $display("FAIL clr_with_err got e=%b s=%b c=%0d exp e=1 s=1 c=1", err_pulse, err_sticky, err_count);
    end
    tick();
    clear = 1'b0;
    checks++;
    if (err_sticky !== 1'b0 || err_count !== 2'd0 || err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL clr_alone got s=%b c=%0d e=%b exp s=0 c=0 e=0", err_sticky, err_count, err_pulse);
    end
    checks++;
    if (gray_out !== 4'b0101 || binary_out !== 4'd6 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL clr_data got g=%b b=%0d v=%b exp g=0101 b=6 v=1", gray_out, binary_out, valid_out);
    end
  endtask

  task automatic test_reset_mid();
    apply(4'b0000);
    checks++;
    if (err_sticky !== 1'b1 || err_count !== 2'd1) begin
      errors++;
      $display("FAIL pre_rst got s=%b c=%0d exp s=1 c=1", err_sticky, err_count);
    end
    gray_in = 4'b0001;
    repeat (3) tick();
    rst_n   = 1'b0;
    gray_in = 4'b0000;
    tick();
    checks++;
    if ({valid_out, gray_out, binary_out, step_up, step_down, err_pulse, err_sticky, err_count} !== 15'd0) begin
      errors++;
      $display("FAIL mid_rst got v=%b g=%b b=%0d p=%b%b%b s=%b c=%0d exp all 0", valid_out, gray_out, binary_out, step_up, step_down, err_pulse, err_sticky, err_count);
    end
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_fill got %b exp 0", valid_out);
    end
    tick();
    checks++;
    if (valid_out !== 1'b1) begin
      errors++;
      $display("FAIL mid_track got %b exp 1", valid_out);
    end
  endtask

`ifdef GRAY_SYNC_DIR_CHECK_EN
  task automatic test_dir();
    repeat (2) tick();
    apply(4'b0001);
    checks++;
    if (step_up !== 1'b1 || err_dir !== 1'b0 || err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL dir_ok got up=%b d=%b e=%b exp up=1 d=0 e=0", step_up, err_dir, err_pulse);
    end
    apply(4'b0000);
    checks++;
    if (step_down !== 1'b1 || err_dir !== 1'b1 || err_pulse !== 1'b1 || err_count !== 2'd1 || err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL dir_bad got dn=%b d=%b e=%b c=%0d s=%b exp 1 1 1 1 1", step_down, err_dir, err_pulse, err_count, err_sticky);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_step_up();
    test_step_down();
    test_errors();
    test_clear();
    test_reset_mid();
`ifdef GRAY_SYNC_DIR_CHECK_EN
    test_dir();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_sync_decoder.md
Name: gray_sync_decoder

Overview:
Receive side of a Gray-coded counter bus. Samples a Gray value produced in another clock domain, synchronizes it into clk, and decodes it to binary. Classifies every sampled change as a legal step up, a legal step down, or an illegal jump, with error flagging and counting. Used wherever Gray counter values or pointers cross into a consuming domain.

Parameters:
WIDTH, 4, Gray/binary width in bits (>=2)
SYNC_STAGES, 2, synchronizer flop count (>=2)
ERR_CNT_W, 8, width of saturating error counter

Ports:
clk  input  1  receive-domain clock
rst_n  input  1  synchronous, active-low reset
gray_in  input  WIDTH  asynchronous Gray code from the source domain
clear  input  1  synchronous clear of err_sticky and err_count
gray_out  output  WIDTH  synchronized Gray value (registered)
binary_out  output  WIDTH  decoded binary of gray_out
valid_out  output  1  outputs meaningful (tracking state)
step_up  output  1  1-cycle pulse: legal +1 step (mod 2^WIDTH)
step_down  output  1  1-cycle pulse: legal -1 step (mod 2^WIDTH)
err_pulse  output  1  1-cycle pulse: illegal change
err_sticky  output  1  set on any err_pulse, held until clear/reset
err_count  output  ERR_CNT_W  saturating count of err_pulse events

Behaviour:
- Reset (rst_n=0 at clk edge): sync chain, gray_out, binary_out, prev registers = 0; valid_out, step_up, step_down, err_pulse, err_sticky = 0; err_count = 0; FSM -> FILL. Reset asserted mid-stream aborts everything at that edge.
- Sync chain: SYNC_STAGES flops on gray_in; the final stage feeds a capture register gray_cur. gray_out = gray_cur.
- Decode: bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] ^ g[i]. Registered with the classification, so binary_out and event pulses are coincident.
- Latency: gray_in change -> gray_out is SYNC_STAGES+1 edges; -> binary_out and event pulse is SYNC_STAGES+2 edges.
- FSM:
  - FILL: count SYNC_STAGES+1 edges after reset release; prev loaded every cycle; no events; valid_out=0.
  - FILL -> TRACK at terminal count; valid_out=1 from the first TRACK cycle.
  - TRACK stays until reset.
- Classification in TRACK, comparing new sample to prev (prev updates every cycle):
  - diff = new ^ prev.
  - popcount(diff)=0 -> no pulse.
  - popcount=1 and bin_new = bin_prev+1 mod 2^WIDTH -> step_up.
  - popcount=1 and bin_new = bin_prev-1 mod 2^WIDTH -> step_down.
  - Anything else, including a single-bit change that is not ±1 (e.g. 0001->0101) or popcount>=2 -> err_pulse.
  - At most one of step_up/step_down/err_pulse is high per cycle.
- Wrap: 1000->0000 (bin 15->0) is step_up; 0000->1000 is step_down.
- err_count increments per err_pulse and saturates at 2^ERR_CNT_W-1.
- clear and err_pulse in the same cycle: err_sticky=1, err_count=1.
- clear alone: err_sticky=0, err_count=0 next edge. clear has no effect on the FSM or the data path.

Optional Feature:
GRAY_SYNC_DIR_CHECK_EN
- Defined: adds parameter EXPECT_DIR (0 up, 1 down, default 0) and output err_dir (1 bit). A legal step opposite to EXPECT_DIR pulses err_dir and err_pulse, increments err_count, and sets err_sticky; step_up/step_down are still reported.
- Undefined: port and parameter absent; both directions are legal.

Decomposition:
- Package gray_pkg: gray2bin and bin2gray functions, popcount function, FSM state enum {FILL, TRACK}.
- Sub-module gray_sync_chain (WIDTH, SYNC_STAGES): reset-to-zero flop chain, instantiated once.

Test Plan:
All cases use WIDTH=4, SYNC_STAGES=2, ERR_CNT_W=2.
- Release reset with gray_in=0000 held -> valid_out=1 on the 3rd edge after release; binary_out=0; no pulses ever.
- Drive Gray up-sequence 0000,0001,0011,0010,...,1000,0000, one per 2 cycles -> step_up once per change; binary_out 0..15 then 0; the 1000->0000 wrap gives step_up; err_sticky stays 0.
- After settle at 0000, drive 1000 then 1001 -> step_down twice; binary_out 15 then 14.
- Drive 0001->0101, then 0000->0011 -> err_pulse each time, binary_out 6 and 2, err_sticky=1, err_count=2; two more jumps -> err_count holds at 3.
- Assert clear in the same cycle as an error -> err_count=1, err_sticky=1; clear alone next -> both 0.
- rst_n=0 mid-stream -> next edge all outputs 0, valid_out=0; valid_out returns 3 edges after release. With GRAY_SYNC_DIR_CHECK_EN, EXPECT_DIR=0, a 0001->0000 change -> step_down plus err_dir and err_pulse.
